// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: word width, the
// multiply/divide unit state encodings and a conditional-negate helper.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_MULT = 2'd1;
  localparam logic [1:0] MD_DIV  = 2'd2;
  localparam logic [1:0] MD_FIN  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = MD_IDLE,
    ST_MULT = MD_MULT,
    ST_DIV  = MD_DIV,
    ST_FIN  = MD_FIN
  } md_state_t;

  // Two's-complement negate when neg is set; abs(x) is cond_neg(x, x[MSB]).
  function automatic logic [WORD_W-1:0] cond_neg(input logic [WORD_W-1:0] x,
                                                 input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// One iteration of unsigned shift-add multiply or restoring divide on a
// 2*WIDTH accumulator. Mult: acc = {partial, multiplier}; div: acc = {rem, quo}.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] shifted;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    shifted = {acc[2*WIDTH-2:0], 1'b0};
    trial   = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, opnd};
    if (is_div) begin
      // Borrow means the trial subtract went negative: keep the shifted remainder.
      acc_next = trial[WIDTH] ? shifted
                              : {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit producing HI/LO for the multicycle MIPS
// control FSM. One bit per cycle on magnitudes; signs are applied at commit.
//
//   state | meaning
//   IDLE  | waiting for start_mult / start_div
//   MULT  | shift-add iterations, busy=1
//   DIV   | restoring-divide iterations, busy=1
//   FIN   | result committed (or div-by-zero), done=1 for one cycle
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  md_state_t          state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_next, prod_signed;
  logic [WIDTH-1:0]   opnd, quo_signed, rem_signed;
  logic               sign_a, sign_b, dz_flag, last_iter;

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .is_div   (state == ST_DIV),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state == ST_MULT) || (state == ST_DIV);
  assign done      = (state == ST_FIN);
  assign div_zero  = (state == ST_FIN) && dz_flag;

  always_comb begin
    prod_signed = (sign_a ^ sign_b) ? (~acc_next + 1'b1) : acc_next;
    quo_signed  = cond_neg(acc_next[WIDTH-1:0], sign_a ^ sign_b);
    rem_signed  = cond_neg(acc_next[2*WIDTH-1:WIDTH], sign_a);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_mult)                  state_next = ST_MULT;
        else if (start_div && b_in != '0) state_next = ST_DIV;
        else if (start_div)              state_next = ST_FIN;
      end
      ST_MULT, ST_DIV: if (last_iter) state_next = ST_FIN;
      default:         state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      dz_flag <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (start_mult || start_div) begin
            cnt     <= '0;
            sign_a  <= a_in[WIDTH-1];
            sign_b  <= b_in[WIDTH-1];
            dz_flag <= !start_mult && (b_in == '0);
            // Mult iterates over the multiplier bits; div shifts the dividend out.
            opnd    <= start_mult ? cond_neg(a_in, a_in[WIDTH-1])
                                  : cond_neg(b_in, b_in[WIDTH-1]);
            acc     <= {{WIDTH{1'b0}}, start_mult ? cond_neg(b_in, b_in[WIDTH-1])
                                                  : cond_neg(a_in, a_in[WIDTH-1])};
          end
        end
        ST_MULT, ST_DIV: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            if (state == ST_MULT) begin
              hi_out <= prod_signed[2*WIDTH-1:WIDTH];
              lo_out <= prod_signed[WIDTH-1:0];
            end else begin
              hi_out <= rem_signed;
              lo_out <= quo_signed;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: a scoreboard queue of expected
// HI/LO/div_zero is popped by a monitor on every done pulse.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult, start_div;
  logic [31:0] a_in, b_in;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_zero;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic [7:0]  id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mult_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a_in       (a_in),
    .b_in       (b_in),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("hi_v%0d", e.id), 64'(hi_out), 64'(e.hi));
          check($sformatf("lo_v%0d", e.id), 64'(lo_out), 64'(e.lo));
          check($sformatf("dz_v%0d", e.id), 64'(div_zero), 64'(e.dz));
        end
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with it idle again.
  // poke: re-pulse start_mult with new operands at cycles 5, 32 and during FIN.
  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input logic [7:0] id, input logic poke);
    int cycles, busy_cnt;
    exp_q.push_back('{hi: ehi, lo: elo, dz: edz, id: id});
    a_in = a; b_in = b;
    start_mult = !is_div; start_div = is_div;
    @(posedge clk); #1;
    start_mult = 1'b0; start_div = 1'b0;
    cycles = 1; busy_cnt = 0;
    while (!done && cycles < 100) begin
      busy_cnt += int'(busy);
      if (poke && (cycles == 5 || cycles == 32)) begin
        start_mult = 1'b1; a_in = 32'd100; b_in = 32'hFFFF_FFFF;
      end
      @(posedge clk); #1;
      start_mult = 1'b0;
      cycles++;
    end
    check($sformatf("latency_v%0d", id), 64'(cycles), (edz && is_div) ? 64'd1 : 64'd33);
    check($sformatf("busy_cycles_v%0d", id), 64'(busy_cnt), (edz && is_div) ? 64'd0 : 64'd32);
    if (poke) start_mult = 1'b1;
    @(posedge clk); #1;
    start_mult = 1'b0;
    check($sformatf("done_one_cycle_v%0d", id), 64'({done, busy}), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {hi_out, lo_out}, 64'd0);
    check("reset_flags", 64'({busy, done, div_zero}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 8'd1, 1'b0);
    run_op(1'b1, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 8'd2, 1'b0);
    // Preload hi/lo = 0x1234/0x5678 via 0x0ACF1234 / 0x2000.
    run_op(1'b1, 32'h0ACF_1234, 32'h2000, 32'h1234, 32'h5678, 1'b0, 8'd3, 1'b0);
    run_op(1'b1, 32'd99, 32'd0, 32'h1234, 32'h5678, 1'b1, 8'd4, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0, 8'd5, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 8'd6, 1'b0);
    run_op(1'b0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 8'd7, 1'b1);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFE, 1'b0, 8'd8, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'd0, 32'd42, 1'b0, 8'd9, 1'b0);

    // Reset in the middle of a divide: no result, no done pulse.
    a_in = 32'hFFFF_FFEF; b_in = 32'd5; start_div = 1'b1;
    @(posedge clk); #1;
    start_div = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_reset_hilo", {hi_out, lo_out}, 64'd0);
    check("mid_reset_flags", 64'({busy, done, div_zero}), 64'd0);
    repeat (40) begin @(posedge clk); #1; end
    run_op(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 8'd10, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
